// File: rtl/counter_checker.sv
// counter_checker: receive-side monitor for the synchronous mode counter.
// It observes the counter's stimulus (ENB, MODO, D) and response (Q, RCO),
// locks a cycle-accurate reference model onto the counter, then flags
// every Q/RCO mismatch with a pulse, sticky flags and saturating counters.
module counter_checker #(
  parameter int WIDTH       = 4,
  parameter int ERR_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             RCO,
  input  logic             CLR_ERR,
  output logic             SYNCED,
  output logic             ERR,
  output logic             ERR_Q,
  output logic             ERR_RCO,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [ERR_W-1:0] CHK_CNT,
  output logic [WIDTH-1:0] EXP_Q
);

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_FAIL   = 2'd2;

  logic [1:0]       state;
  logic             exp_rco;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] pred_q;
  logic             pred_rco;
  logic             mism_q;
  logic             mism_rco;
  logic             mism;
  logic [ERR_W-1:0] err_base;
  logic [ERR_W-1:0] chk_base;

  // Next counter value for one edge of the counter cell.
  function automatic logic [WIDTH-1:0] next_q(input logic [WIDTH-1:0] q,
                                              input logic             enb,
                                              input logic [1:0]       modo,
                                              input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    if (!enb) begin
      r = '0;
    end else begin
      case (modo)
        2'b00:   r = q + WIDTH'(1);
        2'b01:   r = q - WIDTH'(1);
        2'b10:   r = q - WIDTH'(3);
        default: r = d;
      endcase
    end
    return r;
  endfunction

  // Carry/borrow produced by that same edge, decided on the old value.
  function automatic logic next_rco(input logic [WIDTH-1:0] q,
                                    input logic             enb,
                                    input logic [1:0]       modo);
    logic r;
    if (!enb) begin
      r = 1'b0;
    end else begin
      case (modo)
        2'b00:   r = (q == {WIDTH{1'b1}});
        2'b01:   r = (q == '0);
        2'b10:   r = ({1'b0, q} < (WIDTH+1)'(3));
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Saturating increment: counters stick at all ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  // Prediction source and compare: before lock the model follows the observed
  // Q; once locked it runs only from its own value. Case-inequality makes an
  // unknown Q or RCO count as a mismatch in simulation.
  always_comb begin
    base_q   = (state == ST_CHECK) ? EXP_Q : Q;
    pred_q   = next_q(base_q, ENB, MODO, D);
    pred_rco = next_rco(base_q, ENB, MODO);
    mism_q   = (state == ST_CHECK) && (Q !== EXP_Q);
    mism_rco = (state == ST_CHECK) && (RCO !== exp_rco);
    mism     = mism_q || mism_rco;
    err_base = CLR_ERR ? '0 : ERR_CNT;
    chk_base = CLR_ERR ? '0 : CHK_CNT;
  end

  // Lock/check/fail sequencing, model update and error bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= ST_UNSYNC;
      EXP_Q   <= '0;
      exp_rco <= 1'b0;
      ERR     <= 1'b0;
      ERR_Q   <= 1'b0;
      ERR_RCO <= 1'b0;
      ERR_CNT <= '0;
      CHK_CNT <= '0;
    end else begin
      case (state)
        ST_UNSYNC: begin
          EXP_Q   <= pred_q;
          exp_rco <= pred_rco;
          ERR     <= 1'b0;
          if (CLR_ERR) begin
            ERR_Q   <= 1'b0;
            ERR_RCO <= 1'b0;
            ERR_CNT <= '0;
            CHK_CNT <= '0;
          end
          // Clear and load edges make the next Q independent of the old one.
          if (!ENB || (MODO == 2'b11)) state <= ST_CHECK;
        end
        ST_CHECK: begin
          EXP_Q   <= pred_q;
          exp_rco <= pred_rco;
          ERR     <= mism;
          // Clear acts first, so a coincident mismatch still gets recorded.
          ERR_Q   <= (ERR_Q   && !CLR_ERR) || mism_q;
          ERR_RCO <= (ERR_RCO && !CLR_ERR) || mism_rco;
          ERR_CNT <= mism ? sat_inc(err_base) : err_base;
          CHK_CNT <= sat_inc(chk_base);
          if (STOP_ON_ERR && mism) state <= ST_FAIL;
        end
        default: begin
          // FAIL: everything frozen until reset.
          ERR <= 1'b0;
        end
      endcase
    end
  end

  assign SYNCED = (state == ST_CHECK);

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: drives three checkers (4-bit, 4-bit stop-on-error,
// 8-bit) from behavioural counters with fault injection, and scoreboards
// every cycle of their outputs against a rule-level model of the checker.
module tb_counter_checker;

  typedef struct {
    int st;      // 0 unsync, 1 check, 2 fail
    int mq;
    bit mrco;
    bit err, eq, er;
    int ecnt, ccnt;
  } cm_t;

  typedef struct {
    bit sy, er, eq, erc;
    int ec, cc, xq;
  } exp_t;

  localparam int SAT = 65535;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enb = 1'b0;
  logic [1:0] modo = 2'b00;
  logic [7:0] d = 8'h00;
  logic       clr = 1'b0;
  logic [3:0] flip_q = 4'h0;
  logic       flip_rco = 1'b0;

  int cnt4 = 0, cnt8 = 0;
  bit rco4 = 1'b0, rco8 = 1'b0;

  logic [3:0] q4;
  logic       r4;
  logic [7:0] q8;
  logic       r8;

  logic        a_sy, a_er, a_eq, a_erc;
  logic [15:0] a_ec, a_cc;
  logic [3:0]  a_xq;
  logic        s_sy, s_er, s_eq, s_erc;
  logic [15:0] s_ec, s_cc;
  logic [3:0]  s_xq;
  logic        b_sy, b_er, b_eq, b_erc;
  logic [15:0] b_ec, b_cc;
  logic [7:0]  b_xq;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qs[$];
  exp_t qb[$];
  cm_t  m4, m4s, m8;

  always #5 clk = ~clk;

  assign q4 = 4'(cnt4) ^ flip_q;
  assign r4 = rco4 ^ flip_rco;
  assign q8 = 8'(cnt8);
  assign r8 = rco8;

  counter_checker #(.WIDTH(4), .ERR_W(16), .STOP_ON_ERR(1'b0)) dut4 (
    .CLK(clk), .RST_N(rst_n), .ENB(enb), .MODO(modo), .D(d[3:0]), .Q(q4),
    .RCO(r4), .CLR_ERR(clr), .SYNCED(a_sy), .ERR(a_er), .ERR_Q(a_eq),
    .ERR_RCO(a_erc), .ERR_CNT(a_ec), .CHK_CNT(a_cc), .EXP_Q(a_xq));

  counter_checker #(.WIDTH(4), .ERR_W(16), .STOP_ON_ERR(1'b1)) dut4s (
    .CLK(clk), .RST_N(rst_n), .ENB(enb), .MODO(modo), .D(d[3:0]), .Q(q4),
    .RCO(r4), .CLR_ERR(clr), .SYNCED(s_sy), .ERR(s_er), .ERR_Q(s_eq),
    .ERR_RCO(s_erc), .ERR_CNT(s_ec), .CHK_CNT(s_cc), .EXP_Q(s_xq));

  counter_checker #(.WIDTH(8), .ERR_W(16), .STOP_ON_ERR(1'b0)) dut8 (
    .CLK(clk), .RST_N(rst_n), .ENB(enb), .MODO(modo), .D(d), .Q(q8),
    .RCO(r8), .CLR_ERR(clr), .SYNCED(b_sy), .ERR(b_er), .ERR_Q(b_eq),
    .ERR_RCO(b_erc), .ERR_CNT(b_ec), .CHK_CNT(b_cc), .EXP_Q(b_xq));

  // Counter rules in plain modular arithmetic.
  function automatic int nq(int q, bit e, bit [1:0] m, int dv, int w);
    int md = 1 << w;
    if (!e) return 0;
    case (m)
      2'd0:    return (q + 1) % md;
      2'd1:    return (q + md - 1) % md;
      2'd2:    return (q + md - 3) % md;
      default: return dv % md;
    endcase
  endfunction

  function automatic bit nr(int q, bit e, bit [1:0] m, int w);
    int md = 1 << w;
    if (!e) return 1'b0;
    case (m)
      2'd0:    return q == md - 1;
      2'd1:    return q == 0;
      2'd2:    return q <= 2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int smin(int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Checker behaviour for one clock edge.
  function automatic cm_t cm_step(cm_t s, int w, bit stop, bit rst, bit e,
                                  bit [1:0] m, int dv, int q, bit rco, bit c);
    cm_t n = s;
    bit bq, br, bad;
    if (!rst) begin
      n.st = 0; n.mq = 0; n.mrco = 0; n.err = 0; n.eq = 0; n.er = 0;
      n.ecnt = 0; n.ccnt = 0;
      return n;
    end
    if (s.st == 0) begin
      n.mq = nq(q, e, m, dv, w);
      n.mrco = nr(q, e, m, w);
      n.err = 0;
      if (c) begin n.eq = 0; n.er = 0; n.ecnt = 0; n.ccnt = 0; end
      if (!e || m == 2'd3) n.st = 1;
    end else if (s.st == 1) begin
      bq = (q != s.mq);
      br = (rco != s.mrco);
      bad = bq || br;
      if (c) begin n.eq = 0; n.er = 0; n.ecnt = 0; n.ccnt = 0; end
      n.ccnt = smin(n.ccnt + 1);
      if (bad) n.ecnt = smin(n.ecnt + 1);
      n.eq = n.eq | bq;
      n.er = n.er | br;
      n.err = bad;
      n.mq = nq(s.mq, e, m, dv, w);
      n.mrco = nr(s.mq, e, m, w);
      if (stop && bad) n.st = 2;
    end else begin
      n.err = 0;
    end
    return n;
  endfunction

  function automatic exp_t to_exp(cm_t s);
    exp_t x;
    x.sy = (s.st == 1); x.er = s.err; x.eq = s.eq; x.erc = s.er;
    x.ec = s.ecnt; x.cc = s.ccnt; x.xq = s.mq;
    return x;
  endfunction

  // Behavioural counters under test.
  always @(posedge clk) begin
    cnt4 <= nq(cnt4, enb, modo, int'(d), 4);
    rco4 <= nr(cnt4, enb, modo, 4);
    cnt8 <= nq(cnt8, enb, modo, int'(d), 8);
    rco8 <= nr(cnt8, enb, modo, 8);
  end

  // Drive one cycle at a negedge and queue what each checker must show
  // after the following posedge.
  task automatic cyc(bit r, bit e, bit [1:0] m, int dv, bit c, int fq, bit fr);
    int qo4;
    bit ro4;
    rst_n = r; enb = e; modo = m; d = 8'(dv); clr = c;
    flip_q = 4'(fq); flip_rco = fr;
    qo4 = (cnt4 ^ fq) & 15;
    ro4 = rco4 ^ fr;
    m4  = cm_step(m4,  4, 1'b0, r, e, m, dv & 15,  qo4, ro4, c);
    m4s = cm_step(m4s, 4, 1'b1, r, e, m, dv & 15,  qo4, ro4, c);
    m8  = cm_step(m8,  8, 1'b0, r, e, m, dv & 255, cnt8, rco8, c);
    qa.push_back(to_exp(m4));
    qs.push_back(to_exp(m4s));
    qb.push_back(to_exp(m8));
    @(negedge clk);
  endtask

  task automatic cmp_out(string tag, exp_t x, bit sy, bit er, bit eq, bit erc,
                         int ec, int cc, int xq);
    checks++;
    if (sy !== x.sy || er !== x.er || eq !== x.eq || erc !== x.erc ||
        ec != x.ec || cc != x.cc || xq != x.xq) begin
      errors++;
      $display("FAIL %s t=%0t got syn=%0b err=%0b eq=%0b erco=%0b ecnt=%0d ccnt=%0d expq=%0d want syn=%0b err=%0b eq=%0b erco=%0b ecnt=%0d ccnt=%0d expq=%0d",
               tag, $time, sy, er, eq, erc, ec, cc, xq,
               x.sy, x.er, x.eq, x.erc, x.ec, x.cc, x.xq);
    end
  endtask

  task automatic chk(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  // Scoreboard monitor: one popped expectation per DUT per clock.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      cmp_out("sb_w4", x, a_sy, a_er, a_eq, a_erc, int'(a_ec), int'(a_cc), int'(a_xq));
    end
    if (qs.size() > 0) begin
      x = qs.pop_front();
      cmp_out("sb_w4stop", x, s_sy, s_er, s_eq, s_erc, int'(s_ec), int'(s_cc), int'(s_xq));
    end
    if (qb.size() > 0) begin
      x = qb.pop_front();
      cmp_out("sb_w8", x, b_sy, b_er, b_eq, b_erc, int'(b_ec), int'(b_cc), int'(b_xq));
    end
  end

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_synced", int'(a_sy), 0);
    chk("rst_expq", int'(a_xq), 0);

    // Lock on a clear edge, then count through the wrap.
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("sync_after_clear", int'(a_sy), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    chk("up_chk_cnt", int'(a_cc), 18);
    chk("up_err_cnt", int'(a_ec), 0);
    chk("up_expq", int'(a_xq), 1);

    // Load 2, then down-by-3 twice.
    cyc(1, 1, 3, 2, 0, 0, 0);
    chk("load_expq", int'(a_xq), 2);
    cyc(1, 1, 2, 0, 0, 0, 0);
    chk("dn3_expq_a", int'(a_xq), 15);
    cyc(1, 1, 2, 0, 0, 0, 0);
    chk("dn3_expq_b", int'(a_xq), 12);
    chk("dn3_err_cnt", int'(a_ec), 0);

    // RCO fault: stop-on-error checker must freeze in FAIL.
    cyc(1, 1, 0, 0, 0, 0, 1);
    chk("stop_synced", int'(s_sy), 0);
    chk("stop_err_rco", int'(s_erc), 1);
    chk("stop_err_cnt", int'(s_ec), 1);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 0, 1);
    chk("stop_frozen_cnt", int'(s_ec), 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("stop_rst_synced", int'(s_sy), 0);
    chk("stop_rst_err_cnt", int'(s_ec), 0);
    chk("stop_rst_chk_cnt", int'(s_cc), 0);
    chk("stop_rst_expq", int'(s_xq), 0);

    // Q fault when the model expects 4.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 3, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("pre_fault_expq", int'(a_xq), 4);
    cyc(1, 1, 0, 0, 0, 1, 0);
    chk("qf_err_pulse", int'(a_er), 1);
    chk("qf_err_q", int'(a_eq), 1);
    chk("qf_err_rco", int'(a_erc), 0);
    chk("qf_err_cnt", int'(a_ec), 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("qf_err_drop", int'(a_er), 0);

    // Clear coinciding with a mismatch, then clear alone.
    cyc(1, 1, 0, 0, 1, 2, 0);
    chk("clr_mm_err_cnt", int'(a_ec), 1);
    chk("clr_mm_chk_cnt", int'(a_cc), 1);
    chk("clr_mm_err_q", int'(a_eq), 1);
    cyc(1, 1, 0, 0, 1, 0, 0);
    chk("clr_err_cnt", int'(a_ec), 0);
    chk("clr_err_q", int'(a_eq), 0);

    // Decrement from zero at both widths.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("dn_w4_expq", int'(a_xq), 15);
    chk("dn_w8_expq", int'(b_xq), 255);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("dn_w8_err_cnt", int'(b_ec), 0);

    // Randomized traffic with occasional faults, clears and resets.
    for (int i = 0; i < 400; i++) begin
      bit r, e, c, fr;
      int fq;
      r  = ($urandom_range(99) != 0);
      e  = ($urandom_range(9) != 0);
      c  = ($urandom_range(29) == 0);
      fq = ($urandom_range(19) == 0) ? int'($urandom_range(15)) : 0;
      fr = ($urandom_range(24) == 0);
      cyc(r, e, 2'($urandom_range(3)), int'($urandom_range(255)), c, fq, fr);
    end

    @(posedge clk);
    #2;
    chk("sb_drained", qa.size() + qs.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
